// File: rtl/ram_pkg.sv
// Shared encodings for the data RAM: access sizes, controller states and
// the lane/alignment helpers used by the request decoder.
package ram_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] IDLE = 1'b1;

    function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
        logic e;
        case (size)
            SZ_B:    e = 1'b0;
            SZ_H:    e = lane[0];
            SZ_W:    e = |lane;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = 4'b0011 << lane;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// Request/response bus of the data RAM; the master issues loads/stores and
// receives a one-cycle response pulse per accepted request.
interface data_ram_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_bank.sv
// One byte lane of the data RAM: synchronous write with enable and a
// registered read (read-before-write on a same-address collision).
module ram_bank #(
    parameter int AW = 8
) (
    input  logic          RAM_clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:2**AW-1];

    always_ff @(posedge RAM_clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_ram.sv
// Byte-addressable little-endian data RAM with sized loads/stores, a
// one-cycle response pulse and an optional clear sweep after reset.
//   state | meaning
//   INIT  | sweeping zeros into one word per cycle; no requests accepted
//   IDLE  | accepting one request per cycle
module data_ram
    import ram_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic     RAM_clk,
    input  logic     RAM_rst_n,
    data_ram_if.slave bus,
    output logic     init_done
);
    localparam int WI_W = ADDR_W - 2;

    logic [0:0]      state;
    logic [WI_W-1:0] clr_cnt;

    always_ff @(posedge RAM_clk or negedge RAM_rst_n) begin
        if (!RAM_rst_n) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else if (state == INIT) begin
            if (INIT_ZERO == 1'b0 || (&clr_cnt)) begin
                state <= IDLE;
            end
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign init_done     = (state == IDLE);

    logic       acc, err, st, ld, clearing;
    logic [1:0] lane;

    assign acc      = bus.req_ready & bus.req_valid;
    assign lane     = bus.req_addr[1:0];
    assign err      = size_err(bus.req_size, lane);
    assign st       = acc & bus.req_we & ~err;
    assign ld       = acc & ~bus.req_we & ~err;
    assign clearing = (state == INIT) && INIT_ZERO;

    // Replicating the store data lets each lane pick its byte with no shifter.
    logic [31:0] wr_word;
    always_comb begin
        wr_word = bus.req_wdata;
        case (bus.req_size)
            SZ_B:    wr_word = {4{bus.req_wdata[7:0]}};
            SZ_H:    wr_word = {2{bus.req_wdata[15:0]}};
            default: wr_word = bus.req_wdata;
        endcase
    end

    logic [WI_W-1:0] bank_addr;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     rd_word;

    assign bank_addr = (state == INIT) ? clr_cnt : bus.req_addr[ADDR_W-1:2];
    assign be        = clearing ? 4'hF : (st ? lane_mask(bus.req_size, lane) : 4'h0);
    assign wd        = clearing ? 32'h0 : wr_word;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        ram_bank #(.AW(WI_W)) u_bank (
            .RAM_clk (RAM_clk),
            .we      (be[g]),
            .addr    (bank_addr),
            .wdata   (wd[8*g +: 8]),
            .rdata   (rd_word[8*g +: 8])
        );
    end

    logic       rsp_valid_q, rsp_err_q, rd_q, uns_q;
    logic [1:0] size_q, lane_q;

    always_ff @(posedge RAM_clk or negedge RAM_rst_n) begin
        if (!RAM_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_q        <= 1'b0;
            size_q      <= SZ_B;
            lane_q      <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= acc;
            rsp_err_q   <= acc & err;
            rd_q        <= ld;
            if (acc) begin
                size_q <= bus.req_size;
                lane_q <= lane;
                uns_q  <= bus.req_unsigned;
            end
        end
    end

    logic [31:0] shifted, ext;
    assign shifted = rd_word >> {lane_q, 3'b000};

    always_comb begin
        ext = shifted;
        case (size_q)
            SZ_B:    ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = rd_word;
        endcase
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_q ? ext : 32'h0;
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram (ADDR_W = 6): expected responses are queued at
// drive time and checked, including their arrival cycle, by a monitor.
module tb_data_ram;
    import ram_pkg::*;

    localparam int AW = 6;

    logic RAM_clk = 1'b0;
    logic RAM_rst_n;
    logic init_done;

    data_ram_if #(.ADDR_W(AW)) bus ();

    data_ram #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
        .RAM_clk   (RAM_clk),
        .RAM_rst_n (RAM_rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 RAM_clk = ~RAM_clk;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   nchecks = 0;
    int   nerr    = 0;
    int   cyc     = 0;

    always @(posedge RAM_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge RAM_clk) begin
        if (bus.rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_data"}, bus.rsp_rdata, e.data);
                chk({e.tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
                chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end else begin
            chk("idle_rdata", bus.rsp_rdata, 32'h0);
            chk("idle_err", {31'h0, bus.rsp_err}, 32'h0);
            if (q.size() > 0) begin
                chk({q[0].tag, "_missing"}, 32'(q[0].due > cyc), 32'd1);
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_data);
        exp_t e;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        e.tag  = tag;
        e.err  = exp_err;
        e.data = exp_data;
        e.due  = cyc + 1;
        q.push_back(e);
        @(posedge RAM_clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge RAM_clk);
            #1;
        end
    endtask

    task automatic check_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_ready_low"}, {31'h0, bus.req_ready}, 32'h0);
            chk({tag, "_done_low"}, {31'h0, init_done}, 32'h0);
            @(posedge RAM_clk);
            #1;
        end
        chk({tag, "_ready_high"}, {31'h0, bus.req_ready}, 32'h1);
        chk({tag, "_done_high"}, {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RAM_rst_n        = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge RAM_clk);
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst_done", {31'h0, init_done}, 32'h0);
        chk("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);

        RAM_rst_n = 1'b1;
        check_init("init");
        do_req("ld_w20", 1'b0, SZ_W, 1'b0, 6'h20, 32'h0, 1'b0, 32'h0000_0000);

        do_req("st_w04",  1'b1, SZ_W, 1'b0, 6'h04, 32'h8081_F0FF, 1'b0, 32'h0);
        do_req("ld_b06s", 1'b0, SZ_B, 1'b0, 6'h06, 32'h0, 1'b0, 32'hFFFF_FF81);
        do_req("ld_b06u", 1'b0, SZ_B, 1'b1, 6'h06, 32'h0, 1'b0, 32'h0000_0081);
        do_req("ld_h06s", 1'b0, SZ_H, 1'b0, 6'h06, 32'h0, 1'b0, 32'hFFFF_8081);
        do_req("ld_w04",  1'b0, SZ_W, 1'b1, 6'h04, 32'h0, 1'b0, 32'h8081_F0FF);
        do_req("ld_h04u", 1'b0, SZ_H, 1'b1, 6'h04, 32'h0, 1'b0, 32'h0000_F0FF);
        do_req("ld_h04s", 1'b0, SZ_H, 1'b0, 6'h04, 32'h0, 1'b0, 32'hFFFF_F0FF);
        do_req("ld_b04s", 1'b0, SZ_B, 1'b0, 6'h04, 32'h0, 1'b0, 32'hFFFF_FFFF);
        do_req("ld_b07u", 1'b0, SZ_B, 1'b1, 6'h07, 32'h0, 1'b0, 32'h0000_0080);
        idle(2);

        do_req("st_w08",  1'b1, SZ_W, 1'b0, 6'h08, 32'h1122_3344, 1'b0, 32'h0);
        do_req("st_b09",  1'b1, SZ_B, 1'b0, 6'h09, 32'h5566_77AA, 1'b0, 32'h0);
        do_req("ld_w08a", 1'b0, SZ_W, 1'b0, 6'h08, 32'h0, 1'b0, 32'h1122_AA44);
        do_req("st_h0a",  1'b1, SZ_H, 1'b0, 6'h0A, 32'h1234_BEEF, 1'b0, 32'h0);
        do_req("ld_w08b", 1'b0, SZ_W, 1'b0, 6'h08, 32'h0, 1'b0, 32'hBEEF_AA44);
        idle(1);

        do_req("st_w00",   1'b1, SZ_W, 1'b0, 6'h00, 32'h1357_9BDF, 1'b0, 32'h0);
        do_req("err_h03",  1'b0, SZ_H, 1'b0, 6'h03, 32'h0, 1'b1, 32'h0);
        do_req("err_w02",  1'b1, SZ_W, 1'b0, 6'h02, 32'hDEAD_BEEF, 1'b1, 32'h0);
        do_req("err_sz11", 1'b0, SZ_X, 1'b0, 6'h00, 32'h0, 1'b1, 32'h0);
        do_req("err_sz11w", 1'b1, SZ_X, 1'b0, 6'h00, 32'hFFFF_FFFF, 1'b1, 32'h0);
        do_req("ld_w00",   1'b0, SZ_W, 1'b0, 6'h00, 32'h0, 1'b0, 32'h1357_9BDF);

        do_req("st_w10",   1'b1, SZ_W, 1'b0, 6'h10, 32'hCAFE_BABE, 1'b0, 32'h0);
        do_req("ld_w10",   1'b0, SZ_W, 1'b0, 6'h10, 32'h0, 1'b0, 32'hCAFE_BABE);
        idle(3);
        chk("drain1", 32'(q.size()), 32'h0);

        // Reset while a load response is on the bus.
        do_req("ld_mid", 1'b0, SZ_W, 1'b0, 6'h08, 32'h0, 1'b0, 32'hBEEF_AA44);
        bus.req_valid = 1'b0;
        chk("mid_rsp_valid_pre", {31'h0, bus.rsp_valid}, 32'h1);
        RAM_rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("mid_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("mid_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("mid_rsp_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("mid_rsp_done", {31'h0, init_done}, 32'h0);
        @(posedge RAM_clk);
        #1;
        RAM_rst_n = 1'b1;

        repeat (5) @(posedge RAM_clk);
        #1;
        chk("init5_ready", {31'h0, bus.req_ready}, 32'h0);
        RAM_rst_n = 1'b0;
        #1;
        chk("init5_rst_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("init5_rst_done", {31'h0, init_done}, 32'h0);
        chk("init5_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(posedge RAM_clk);
        #1;
        RAM_rst_n = 1'b1;
        check_init("reinit");

        do_req("clr_w04", 1'b0, SZ_W, 1'b0, 6'h04, 32'h0, 1'b0, 32'h0);
        do_req("clr_w08", 1'b0, SZ_W, 1'b0, 6'h08, 32'h0, 1'b0, 32'h0);
        do_req("clr_w3c", 1'b0, SZ_W, 1'b0, 6'h3C, 32'h0, 1'b0, 32'h0);
        idle(3);
        chk("drain2", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
